// File: rtl/cnn_sram_loader.sv
// cnn_sram_loader: streams host words into the CNN engine's Matrix and Weight
// SRAMs, kicks the engine with a one-cycle go, then follows its busy signal to
// report completion (or a busy timeout).
module cnn_sram_loader #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] matrix_words,
  input  logic [ADDR_W-1:0] weight_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              Matrix_Write_Enable,
  output logic [ADDR_W-1:0] Matrix_Write_Address,
  output logic [DATA_W-1:0] Matrix_Write_Data,
  output logic              Weight_Write_Enable,
  output logic [ADDR_W-1:0] Weight_Write_Address,
  output logic [DATA_W-1:0] Weight_Write_Data,
  output logic              go,
  input  logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TW-1:0]     T_ONE    = TW'(1);
  localparam logic [TW-1:0]     T_LAST   = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_W,
    S_KICK,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] m_cnt;
  logic [ADDR_W-1:0] w_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [TW-1:0]     tcnt;
  logic              xfer;
  logic              last_m;
  logic              last_w;
  logic              timeout_hit;

  assign in_ready    = (state == S_LOAD_M) || (state == S_LOAD_W);
  assign xfer        = in_valid && in_ready;
  assign last_m      = (addr_cnt == (m_cnt - ADDR_ONE));
  assign last_w      = (addr_cnt == (w_cnt - ADDR_ONE));
  assign timeout_hit = (tcnt == T_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (matrix_words != '0)      state_next = S_LOAD_M;
          else if (weight_words != '0) state_next = S_LOAD_W;
          else                         state_next = S_KICK;
        end
      end
      S_LOAD_M: begin
        if (xfer && last_m) state_next = (w_cnt != '0) ? S_LOAD_W : S_KICK;
      end
      S_LOAD_W: begin
        if (xfer && last_w) state_next = S_KICK;
      end
      S_KICK:      state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (busy)             state_next = S_WAIT_DONE;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_WAIT_DONE: begin
        if (!busy) state_next = S_DONE;
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Word counts captured on start; shared address counter walks each SRAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt    <= '0;
      w_cnt    <= '0;
      addr_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        m_cnt    <= matrix_words;
        w_cnt    <= weight_words;
        addr_cnt <= '0;
      end else if (state == S_LOAD_M && xfer) begin
        addr_cnt <= last_m ? '0 : addr_cnt + ADDR_ONE;
      end else if (state == S_LOAD_W && xfer) begin
        addr_cnt <= last_w ? '0 : addr_cnt + ADDR_ONE;
      end
    end
  end

  // Matrix SRAM write port: one-cycle-late strobe, address/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Matrix_Write_Enable  <= 1'b0;
      Matrix_Write_Address <= '0;
      Matrix_Write_Data    <= '0;
    end else begin
      Matrix_Write_Enable <= (state == S_LOAD_M) && xfer;
      if (state == S_LOAD_M && xfer) begin
        Matrix_Write_Address <= addr_cnt;
        Matrix_Write_Data    <= in_data;
      end
    end
  end

  // Weight SRAM write port: same timing as the Matrix port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Weight_Write_Enable  <= 1'b0;
      Weight_Write_Address <= '0;
      Weight_Write_Data    <= '0;
    end else begin
      Weight_Write_Enable <= (state == S_LOAD_W) && xfer;
      if (state == S_LOAD_W && xfer) begin
        Weight_Write_Address <= addr_cnt;
        Weight_Write_Data    <= in_data;
      end
    end
  end

  // Engine control: go/done pulses, busy timeout counter, sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go    <= 1'b0;
      done  <= 1'b0;
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      go   <= (state == S_KICK);
      done <= (state == S_DONE);
      if (state == S_KICK)           tcnt <= '0;
      else if (state == S_WAIT_BUSY) tcnt <= tcnt + T_ONE;
      if (state == S_IDLE && start) error <= 1'b0;
      else if (state == S_WAIT_BUSY && !busy && timeout_hit) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_sram_loader.sv
// Self-checking bench for cnn_sram_loader: scoreboard of expected SRAM writes,
// a small engine model driving busy, and one task per scenario.
module tb_cnn_sram_loader;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] matrix_words = '0;
  logic [AW-1:0] weight_words = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          busy = 1'b0;
  logic          in_ready;
  logic          Matrix_Write_Enable;
  logic [AW-1:0] Matrix_Write_Address;
  logic [DW-1:0] Matrix_Write_Data;
  logic          Weight_Write_Enable;
  logic [AW-1:0] Weight_Write_Address;
  logic [DW-1:0] Weight_Write_Data;
  logic          go;
  logic          done;
  logic          error;

  cnn_sram_loader #(.ADDR_W(AW), .DATA_W(DW), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .matrix_words(matrix_words), .weight_words(weight_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .Matrix_Write_Enable(Matrix_Write_Enable),
    .Matrix_Write_Address(Matrix_Write_Address),
    .Matrix_Write_Data(Matrix_Write_Data),
    .Weight_Write_Enable(Weight_Write_Enable),
    .Weight_Write_Address(Weight_Write_Address),
    .Weight_Write_Data(Weight_Write_Data),
    .go(go), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [61:0] all_out;
  assign all_out = {in_ready, Matrix_Write_Enable, Matrix_Write_Address, Matrix_Write_Data,
                    Weight_Write_Enable, Weight_Write_Address, Weight_Write_Data,
                    go, done, error};

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [AW+DW-1:0] mq[$];
  logic [AW+DW-1:0] wq[$];

  int m_wr_cnt = 0, w_wr_cnt = 0, go_cnt = 0, done_cnt = 0;
  int go_cyc = 0, done_cyc = 0, err_cyc = 0, last_m_cyc = 0, last_w_cyc = 0;
  int bfall_cyc = 0, st_cyc = 0;
  bit err_prev = 1'b0;
  bit eng_en = 1'b1;
  int busy_len = 2;
  bit eng_pend = 1'b0;
  int eng_left = 0;

  always @(posedge clk) cyc++;

  // Engine model: busy rises the cycle after go and stays high busy_len cycles.
  always @(negedge clk) begin
    if (!reset) begin
      busy = 1'b0; eng_pend = 1'b0; eng_left = 0;
    end else begin
      if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin busy = 1'b0; bfall_cyc = cyc; end
      end else if (eng_pend) begin
        eng_pend = 1'b0; busy = 1'b1; eng_left = busy_len;
      end
      if (go && eng_en) eng_pend = 1'b1;
    end
  end

  // Write monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    logic [AW+DW-1:0] exp_w;
    if (reset) begin
      if (Matrix_Write_Enable) begin
        total++; m_wr_cnt++; last_m_cyc = cyc;
        if (mq.size() == 0)
          $display("FAIL m_write unexpected: addr=%0h data=%0h, required no write",
                   Matrix_Write_Address, Matrix_Write_Data);
        else begin
          exp_w = mq.pop_front();
          if ({Matrix_Write_Address, Matrix_Write_Data} !== exp_w)
            $display("FAIL m_write: addr=%0h data=%0h, required addr=%0h data=%0h",
                     Matrix_Write_Address, Matrix_Write_Data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
          else passed++;
        end
      end
      if (Weight_Write_Enable) begin
        total++; w_wr_cnt++; last_w_cyc = cyc;
        if (wq.size() == 0)
          $display("FAIL w_write unexpected: addr=%0h data=%0h, required no write",
                   Weight_Write_Address, Weight_Write_Data);
        else begin
          exp_w = wq.pop_front();
          if ({Weight_Write_Address, Weight_Write_Data} !== exp_w)
            $display("FAIL w_write: addr=%0h data=%0h, required addr=%0h data=%0h",
                     Weight_Write_Address, Weight_Write_Data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
          else passed++;
        end
      end
      if (go) begin go_cnt++; go_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
    end else begin
      err_prev = 1'b0;
    end
  end

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic pulse_start(input int mw, input int ww);
    matrix_words = mw[AW-1:0];
    weight_words = ww[AW-1:0];
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one word; expected write is queued once in_ready shows it will transfer.
  task automatic send_word(input logic [DW-1:0] d, input bit to_m,
                           input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (in_ready) begin
        if (to_m) mq.push_back({a, d});
        else      wq.push_back({a, d});
        ok = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input int mw, input int ww, input bit gap, input bit rnd);
    bit ok;
    logic [DW-1:0] d;
    for (int i = 0; i < mw + ww; i++) begin
      d = rnd ? DW'($urandom) : (DW'(i) ^ 16'h5A5A);
      if (i < mw) send_word(d, 1'b1, i[AW-1:0], ok);
      else        send_word(d, 1'b0, AW'(i - mw), ok);
      if (!ok) begin
        total++;
        $display("FAIL feed_handshake: word %0d not accepted within 50 cycles, required acceptance", i);
        return;
      end
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int k = 0; k < limit && done_cnt == d0; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (all_out !== '0) $display("FAIL idle_outputs: got %h, required 0", all_out);
    else passed++;
  endtask

  task automatic test_single;
    int g0, d0, m0, w0;
    bit ok;
    g0 = go_cnt; d0 = done_cnt; m0 = m_wr_cnt; w0 = w_wr_cnt;
    eng_en = 1'b1; busy_len = 2;
    pulse_start(1, 1);
    send_word(16'hA5C3, 1'b1, 12'd0, ok);
    if (ok) send_word(16'h01FF, 1'b0, 12'd0, ok);
    total++;
    if (!ok) $display("FAIL single_handshake: got not accepted, required accepted");
    else passed++;
    wait_done(d0, 50);
    total++;
    if (m_wr_cnt - m0 != 1 || w_wr_cnt - w0 != 1)
      $display("FAIL single_write_counts: got m=%0d w=%0d, required 1 1", m_wr_cnt - m0, w_wr_cnt - w0);
    else passed++;
    total++;
    if (last_w_cyc != last_m_cyc + 1)
      $display("FAIL single_w_after_m: got w_cyc=%0d m_cyc=%0d, required w=m+1", last_w_cyc, last_m_cyc);
    else passed++;
    total++;
    if (go_cnt - g0 != 1 || done_cnt - d0 != 1)
      $display("FAIL single_pulses: got go=%0d done=%0d, required 1 1", go_cnt - g0, done_cnt - d0);
    else passed++;
    total++;
    if (done_cyc - bfall_cyc < 1 || done_cyc - bfall_cyc > 2)
      $display("FAIL single_done_timing: got done %0d cycles after busy fall, required 1..2", done_cyc - bfall_cyc);
    else passed++;
    total++;
    if (error !== 1'b0) $display("FAIL single_error: got %b, required 0", error);
    else passed++;
  endtask

  task automatic test_stall;
    int g0, d0, m0, w0;
    g0 = go_cnt; d0 = done_cnt; m0 = m_wr_cnt; w0 = w_wr_cnt;
    busy_len = 3;
    pulse_start(4, 3);
    feed(4, 3, 1'b1, 1'b1);
    wait_done(d0, 60);
    total++;
    if (m_wr_cnt - m0 != 4 || w_wr_cnt - w0 != 3)
      $display("FAIL stall_write_counts: got m=%0d w=%0d, required 4 3", m_wr_cnt - m0, w_wr_cnt - w0);
    else passed++;
    total++;
    if (mq.size() != 0 || wq.size() != 0)
      $display("FAIL stall_pending: got mq=%0d wq=%0d, required 0 0", mq.size(), wq.size());
    else passed++;
    total++;
    if (go_cnt - g0 != 1 || done_cnt - d0 != 1)
      $display("FAIL stall_pulses: got go=%0d done=%0d, required 1 1", go_cnt - g0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_zero_counts;
    int g0, d0, m0, w0;
    g0 = go_cnt; d0 = done_cnt; m0 = m_wr_cnt; w0 = w_wr_cnt;
    busy_len = 2;
    in_valid = 1'b1; in_data = 16'hDEAD;
    pulse_start(0, 0);
    wait_done(d0, 50);
    in_valid = 1'b0;
    total++;
    if (go_cnt - g0 != 1 || go_cyc != st_cyc + 2)
      $display("FAIL zero_go: got count=%0d cycle=+%0d, required 1 at +2", go_cnt - g0, go_cyc - st_cyc);
    else passed++;
    total++;
    if (m_wr_cnt != m0 || w_wr_cnt != w0)
      $display("FAIL zero_no_writes: got m=%0d w=%0d, required 0 0", m_wr_cnt - m0, w_wr_cnt - w0);
    else passed++;
    total++;
    if (done_cnt - d0 != 1 || error !== 1'b0)
      $display("FAIL zero_done: got done=%0d error=%b, required 1 0", done_cnt - d0, error);
    else passed++;
  endtask

  task automatic test_timeout;
    int d0;
    d0 = done_cnt;
    eng_en = 1'b0;
    pulse_start(0, 0);
    wait_done(d0, 40);
    total++;
    if (done_cnt - d0 != 1 || err_cyc != go_cyc + 8)
      $display("FAIL timeout_error: got done=%0d err at go+%0d, required 1 at go+8", done_cnt - d0, err_cyc - go_cyc);
    else passed++;
    total++;
    if (done_cyc != err_cyc + 1)
      $display("FAIL timeout_done_timing: got done at err+%0d, required err+1", done_cyc - err_cyc);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (error !== 1'b1) $display("FAIL timeout_sticky: got %b, required 1", error);
    else passed++;
    eng_en = 1'b1;
    d0 = done_cnt;
    pulse_start(0, 0);
    total++;
    if (error !== 1'b0) $display("FAIL timeout_clear_on_start: got %b, required 0", error);
    else passed++;
    wait_done(d0, 50);
    total++;
    if (done_cnt - d0 != 1 || error !== 1'b0)
      $display("FAIL timeout_rerun: got done=%0d error=%b, required 1 0", done_cnt - d0, error);
    else passed++;
  endtask

  task automatic test_reset_abort;
    int d0, m0;
    bit ok;
    m0 = m_wr_cnt;
    pulse_start(4, 2);
    send_word(16'h1111, 1'b1, 12'd0, ok);
    if (ok) send_word(16'h2222, 1'b1, 12'd1, ok);
    #2 reset = 1'b0;
    #1;
    total++;
    if (all_out !== '0) $display("FAIL abort_outputs: got %h, required 0", all_out);
    else passed++;
    @(negedge clk);
    total++;
    if (all_out !== '0 || m_wr_cnt - m0 != 2 || mq.size() != 0)
      $display("FAIL abort_held: got out=%h writes=%0d pending=%0d, required 0 2 0",
               all_out, m_wr_cnt - m0, mq.size());
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    d0 = done_cnt; m0 = m_wr_cnt;
    pulse_start(2, 1);
    feed(2, 1, 1'b0, 1'b1);
    wait_done(d0, 50);
    total++;
    if (m_wr_cnt - m0 != 2 || done_cnt - d0 != 1 || mq.size() != 0 || wq.size() != 0)
      $display("FAIL abort_reload: got m=%0d done=%0d pending=%0d/%0d, required 2 1 0/0",
               m_wr_cnt - m0, done_cnt - d0, mq.size(), wq.size());
    else passed++;
  endtask

  task automatic test_ignore_start;
    int g0, d0, m0, w0;
    bit ok;
    g0 = go_cnt; d0 = done_cnt; m0 = m_wr_cnt; w0 = w_wr_cnt;
    busy_len = 6;
    pulse_start(3, 3);
    feed(3, 1, 1'b0, 1'b1);
    pulse_start(9, 9);
    send_word(16'hBEEF, 1'b0, 12'd1, ok);
    if (ok) send_word(16'hCAFE, 1'b0, 12'd2, ok);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    total++;
    if (!ok || busy !== 1'b1)
      $display("FAIL ignore_reach_busy: got accepted=%b busy=%b, required 1 1", ok, busy);
    else passed++;
    pulse_start(5, 5);
    wait_done(d0, 50);
    repeat (20) @(negedge clk);
    total++;
    if (m_wr_cnt - m0 != 3 || w_wr_cnt - w0 != 3)
      $display("FAIL ignore_write_counts: got m=%0d w=%0d, required 3 3", m_wr_cnt - m0, w_wr_cnt - w0);
    else passed++;
    total++;
    if (go_cnt - g0 != 1 || done_cnt - d0 != 1)
      $display("FAIL ignore_pulses: got go=%0d done=%0d, required 1 1", go_cnt - g0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_max_count;
    int d0, w0;
    d0 = done_cnt; w0 = w_wr_cnt;
    busy_len = 1;
    pulse_start(0, 4095);
    feed(0, 4095, 1'b0, 1'b0);
    wait_done(d0, 100);
    total++;
    if (w_wr_cnt - w0 != 4095 || wq.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL max_count: got writes=%0d pending=%0d done=%0d, required 4095 0 1",
               w_wr_cnt - w0, wq.size(), done_cnt - d0);
    else passed++;
    total++;
    if (Weight_Write_Address !== 12'hFFE)
      $display("FAIL max_last_addr: got %h, required ffe", Weight_Write_Address);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_zero_counts;
    test_timeout;
    test_reset_abort;
    test_ignore_start;
    test_max_count;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
